button_events: RTL and testbench
================================

Name: button_events

Overview:
- Gesture classifier sitting directly downstream of the debounce / hyster stage.
- Consumes the clean, synchronized button level and emits single-cycle event pulses: press, release, click, double_click and long_press.
- Gives a UI/LED controller discrete button events instead of a raw level; all outputs are registered.

Parameters:
LONG_TIME, 16, cycles the button must stay held (counted from the press pulse) before long_press fires; legal range 2..2**CNT_W-1
DCLICK_TIME, 8, cycles after a short release during which a second press forms a double click; legal range 2..2**CNT_W-1
CNT_W, 8, width of the internal state timer

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  reset, asynchronous and active-high; clears all state and outputs
in  input  1  debounced button level (1 = pressed), synchronous to clk
press  output  1  one-cycle pulse on every rising edge of in
release  output  1  one-cycle pulse on every falling edge of in
click  output  1  one-cycle pulse for a completed single short press with no second press
double_click  output  1  one-cycle pulse on release of the second short press
long_press  output  1  one-cycle pulse when a press reaches LONG_TIME
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: in_d=0, state=IDLE, timer=0, all outputs 0. Reset asserted mid-gesture abandons it with no pulse.
- in held high across reset release is seen as a rising edge, so press fires one cycle after the first clock edge.
- Edge detect: in_d registers in.
  - rise = in & ~in_d; fall = ~in & in_d.
  - press and release are registered: each is high for exactly the one cycle after the edge at which rise/fall was sampled.
- Timer:
  - Cleared to 0 on every state transition.
  - Otherwise increments each cycle and saturates at all-ones; never wraps.
- FSM states: IDLE, DOWN1, WAIT2, DOWN2, HOLD.
  - IDLE: on rise go to DOWN1.
  - DOWN1:
    - fall with timer < LONG_TIME-1: go to WAIT2.
    - timer == LONG_TIME-1 with in=1: go to HOLD and pulse long_press.
  - WAIT2:
    - rise with timer <= DCLICK_TIME-1: go to DOWN2.
    - timer == DCLICK_TIME-1 with no rise: go to IDLE and pulse click.
  - DOWN2:
    - fall with timer < LONG_TIME-1: go to IDLE and pulse double_click.
    - timer == LONG_TIME-1 with in=1: go to HOLD and pulse long_press; the pending first click is discarded (no click).
  - HOLD: on fall go to IDLE; release only, no other event.
- Event pulse timing:
  - long_press is high exactly LONG_TIME cycles after the corresponding press pulse.
  - click is high exactly DCLICK_TIME cycles after the release pulse.
  - double_click is high in the same cycle as the second release pulse.
- Simultaneous events:
  - fall sampled on the long threshold cycle: fall wins (short path, no long_press).
  - rise sampled on the WAIT2 expiry cycle: rise wins (DOWN2, no click).
- Pulse exclusivity: at most one of click/double_click/long_press per cycle. press/release may coincide with double_click only as stated above.
- busy is a registered flag, high in every cycle the state is not IDLE.
- in is assumed already debounced; no glitch filtering here. A 1-cycle high pulse on in is a valid short press.
- Out-of-range parameters are a configuration error; no runtime check.

Test Plan:
- Single click: rst low; in rises at edge 10 and falls at edge 14 -> press at cycle 11, release at cycle 15, click at cycle 23 (15+8), busy low from cycle 24; no other pulses.
- Long press: in high at edge 10, held 30 cycles -> press 11, long_press 27 (11+16), no click; release one cycle after fall; busy drops the cycle after release.
- Double click:
  - in 1 at edges 10..12, 0 at edges 13..15, 1 at edges 16..18, 0 from edge 19.
  - Expected: press at 11 and 17, release at 14 and 20, double_click at 20, no click at any time.
- Window boundary:
  - Second rise sampled exactly DCLICK_TIME-1 cycles into WAIT2 -> double path taken, no click.
  - Second rise one cycle later -> click fires, then a fresh press starts a new DOWN1.
- Long threshold race and second-press long:
  - fall sampled on the LONG_TIME-1 cycle -> no long_press; click follows 8 cycles after release.
  - Short press followed by a 20-cycle second press -> long_press only, no click, no double_click.
- Reset mid-operation: assert rst asynchronously in WAIT2 (between clock edges) -> all outputs 0 immediately, no click ever; with in=1 at rst release -> press one cycle after first edge.

Source files
------------

// File: rtl/button_events.sv
// button_events: classifies a debounced button level into press/release/click/double-click/long-press pulses
module button_events #(
    parameter int LONG_TIME   = 16,
    parameter int DCLICK_TIME = 8,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic double_click_o,
    output logic long_press_o,
    output logic busy_o
);
    typedef enum logic [2:0] {IDLE, DOWN1, WAIT2, DOWN2, HOLD} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DCLICK_TIME - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             in_q;
    logic             press_q, release_q, click_q, dclick_q, long_q, busy_q;
    logic             click_d, dclick_d, long_d;
    logic             rise, fall, long_hit, wait_hit;

    assign rise     = in_i & ~in_q;
    assign fall     = ~in_i & in_q;
    assign long_hit = in_i && timer_q == LONG_LAST;
    assign wait_hit = timer_q == WAIT_LAST;

    assign press_o        = press_q;
    assign release_o      = release_q;
    assign click_o        = click_q;
    assign double_click_o = dclick_q;
    assign long_press_o   = long_q;
    assign busy_o         = busy_q;

    // Gesture FSM: fall beats the long threshold and rise beats the click window expiry
    always_comb begin
        state_d  = state_q;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE:  if (rise) state_d = DOWN1;
            DOWN1: begin
                if (fall) state_d = WAIT2;
                else if (long_hit) begin
                    state_d = HOLD;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (rise) state_d = DOWN2;
                else if (wait_hit) begin
                    state_d = IDLE;
                    click_d = 1'b1;
                end
            end
            DOWN2: begin
                if (fall) begin
                    state_d  = IDLE;
                    dclick_d = 1'b1;
                end else if (long_hit) begin
                    state_d = HOLD;
                    long_d  = 1'b1;
                end
            end
            HOLD:    if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q) ? '0 : (&timer_q ? timer_q : timer_q + CNT_W'(1));
    end

    // State, timer, edge history and registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            in_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            in_q      <= in_i;
            press_q   <= rise;
            release_q <= fall;
            click_q   <= click_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            busy_q    <= state_q != IDLE;
        end
    end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: scoreboard bench for the button gesture classifier
module tb_button_events;
    localparam int L = 16;
    localparam int D = 8;
    localparam logic [4:0] PR = 5'b10000;
    localparam logic [4:0] RL = 5'b01000;
    localparam logic [4:0] CK = 5'b00100;
    localparam logic [4:0] DC = 5'b00010;
    localparam logic [4:0] LP = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_i = 1'b0;
    logic press_o, release_o, click_o, double_click_o, long_press_o, busy_o;

    exp_t evq[$];
    exp_t bzq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   p, r;

    button_events #(.LONG_TIME(L), .DCLICK_TIME(D), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_i           (in_i),
        .press_o        (press_o),
        .release_o      (release_o),
        .click_o        (click_o),
        .double_click_o (double_click_o),
        .long_press_o   (long_press_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expectations kept sorted by cycle; bz selects the busy queue
    function automatic void sb_push(input bit bz, input int c, input logic [4:0] v);
        exp_t e;
        int   i = 0;
        e.cyc = c;
        e.v   = v;
        if (bz) begin
            while (i < bzq.size() && bzq[i].cyc <= c) i++;
            bzq.insert(i, e);
        end else begin
            while (i < evq.size() && evq[i].cyc <= c) i++;
            evq.insert(i, e);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // every cycle: pulse vector must equal the OR of expectations due now; busy checked where scheduled
    always @(negedge clk) begin
        logic [4:0] e;
        e = '0;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            if (evq[0].cyc < cyc) chk("stale_ev", 32'(evq[0].cyc), 32'(cyc));
            else e |= evq[0].v;
            void'(evq.pop_front());
        end
        chk($sformatf("ev@%0d", cyc),
            32'({press_o, release_o, click_o, double_click_o, long_press_o}), 32'(e));
        while (bzq.size() > 0 && bzq[0].cyc <= cyc) begin
            if (bzq[0].cyc < cyc) chk("stale_busy", 32'(bzq[0].cyc), 32'(cyc));
            else chk($sformatf("busy@%0d", cyc), 32'(busy_o), 32'(bzq[0].v[0]));
            void'(bzq.pop_front());
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1 chk("rst_outputs",
               32'({press_o, release_o, click_o, double_click_o, long_press_o, busy_o}), 32'd0);
        step(3);
        rst = 1'b0;
        step(5);

        // single click
        p = cyc + 1; in_i = 1'b1;
        sb_push(0, p, PR); sb_push(1, p, 5'd0); sb_push(1, p + 1, 5'd1);
        step(4);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(0, r + D, CK);
        sb_push(1, r + D, 5'd1); sb_push(1, r + D + 1, 5'd0);
        step(20);

        // long press held 30 cycles
        p = cyc + 1; in_i = 1'b1;
        sb_push(0, p, PR); sb_push(0, p + L, LP);
        step(30);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(1, r, 5'd1); sb_push(1, r + 1, 5'd0);
        step(10);

        // double click 3/3/3
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(3);
        in_i = 1'b0; sb_push(0, cyc + 1, RL);
        step(3);
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(3);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL | DC); sb_push(1, r, 5'd1); sb_push(1, r + 1, 5'd0);
        step(20);

        // second rise on the last window cycle: double path
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(2);
        in_i = 1'b0; sb_push(0, cyc + 1, RL);
        step(D);
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(2);
        in_i = 1'b0; sb_push(0, cyc + 1, RL | DC);
        step(20);

        // second rise one cycle late: click, then a fresh gesture
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(2);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(0, r + D, CK); sb_push(1, r + D + 1, 5'd0);
        step(D + 1);
        p = cyc + 1; in_i = 1'b1;
        sb_push(0, p, PR); sb_push(1, p + 1, 5'd1);
        step(2);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(0, r + D, CK);
        step(20);

        // fall on the long threshold cycle: short path wins
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(L);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(0, r + D, CK);
        step(20);

        // one cycle longer: long_press
        p = cyc + 1; in_i = 1'b1;
        sb_push(0, p, PR); sb_push(0, p + L, LP);
        step(L + 1);
        in_i = 1'b0; sb_push(0, cyc + 1, RL);
        step(10);

        // short press then 20-cycle second press: long only
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(2);
        in_i = 1'b0; sb_push(0, cyc + 1, RL);
        step(3);
        p = cyc + 1; in_i = 1'b1;
        sb_push(0, p, PR); sb_push(0, p + L, LP);
        step(20);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(1, r + 1, 5'd0);
        step(20);

        // async reset while waiting for a second press
        in_i = 1'b1; sb_push(0, cyc + 1, PR);
        step(2);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(0, r + D, CK);
        step(3);
        chk("busy_pre_rst", 32'(busy_o), 32'd1);
        #2 rst = 1'b1;
        evq.delete();
        bzq.delete();
        #1 chk("rst_async",
               32'({press_o, release_o, click_o, double_click_o, long_press_o, busy_o}), 32'd0);
        in_i = 1'b1;
        step(2);
        rst = 1'b0;
        sb_push(0, cyc + 1, PR);
        step(3);
        r = cyc + 1; in_i = 1'b0;
        sb_push(0, r, RL); sb_push(0, r + D, CK);
        step(20);

        chk("sb_drain", 32'(evq.size() + bzq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
